qpsk_frame_ctrl: RTL and testbench
==================================

# qpsk_frame_ctrl

Frame sequencer that feeds the QPSK modulator's 1-bit I/Q symbol input. On a start pulse it emits a fixed preamble, a 16-bit length header and the payload bytes, two bits per symbol. It then holds a silent inter-frame gap and signals completion. It sits between the byte-stream source (packet buffer/FIFO) and the modulator, and drives the modulator's valid/ready input handshake.

## Interface
- PREAMBLE_SYMS, 32: preamble length in symbols (even, ≥2).
- GAP_CYCLES, 16: clock cycles of silence after the last symbol (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  frame request pulse; honoured only in IDLE.
- frame_len  in  16  payload byte count; latched on an accepted start; 0 legal.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse at the end of GAP.
- underrun  out  1  sticky: payload byte needed but in_valid low; cleared on an accepted start.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_i  out  1  symbol I bit to modulator.
- out_q  out  1  symbol Q bit to modulator.
- out_valid  out  1  symbol valid.
- out_ready  in  1  modulator ready; symbol transfers when out_valid & out_ready.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- FSM states and transitions:
  - IDLE → PREAMBLE on start.
  - PREAMBLE → HEADER after PREAMBLE_SYMS symbols.
  - HEADER → PAYLOAD after 8 symbols, or → GAP if the latched length is 0.
  - PAYLOAD → GAP after 4·frame_len symbols.
  - GAP → IDLE after GAP_CYCLES cycles; done pulses on this transition.
- Output stage: out_i, out_q and out_valid form one register. It loads when ~out_valid | out_ready. While out_valid & ~out_ready, the symbol is held stable.
- Preamble symbol k: {i,q} = 2'b00 for even k, 2'b11 for odd k (k from 0).
- Header: latched frame_len, MSB first; symbol j carries bits [15−2j] on i and [14−2j] on q.
- Payload: byte MSB first; bits[7:6], [5:4], [3:2], [1:0] → {i,q}.
- in_ready = (state==PAYLOAD) & bytes_left≠0 & (byte shifter empty, or its last symbol loads this cycle). Zero-bubble: one symbol per cycle is sustained while out_ready and in_valid stay high.
- Underrun: if a byte is needed and in_valid=0, no symbol loads, out_valid falls after the pending transfer, and underrun sets. Sequencing resumes on the next in_valid, with no symbol lost or duplicated.
- Symbol counts are bytes_left (16-bit down-counter) and a 2-bit intra-byte index. Counters never wrap; the state exits when the last symbol transfers.
- GAP: the counter starts on the cycle after the final symbol handshake. out_valid=0 and in_ready=0 throughout.
- start while busy: ignored; frame_len is not relatched.
- Async reset mid-frame: immediate return to reset values. The partial frame is dropped and no done is issued.

## Timing
- start sampled at edge t → busy=1 after t. The first preamble symbol is out_valid=1 after edge t+1 (2-cycle latency).
- Total frame with continuous out_ready/in_valid: (PREAMBLE_SYMS+8+4·frame_len) symbol cycles + GAP_CYCLES. done is high for one cycle; busy falls on the same edge.
- The earliest next start is accepted in the cycle after done (IDLE).
- in_ready is combinational from out_ready and state. All other outputs are registered.

## Structure
- qpsk_pkg: state enum (IDLE, PREAMBLE, HEADER, PAYLOAD, GAP), preamble symbol constants (2'b00/2'b11), header width (16), symbols per byte (4).
- Sub-module qpsk_sym_shifter: parallel word load, emits 2 bits per advance, empty flag. Used for both the header (16-bit) and the payload (8-bit); width is parameterised.

## Test plan
- Reset mid-PAYLOAD (rst_n low for 1 cycle) → all outputs 0 immediately; no done; next start produces a full frame from preamble.
- PREAMBLE_SYMS=4, frame_len=1, in_data=8'hB4, out_ready=1 → symbols 00,11,00,11, header 00×7 then 01, payload 10,11,01,00; out_valid low for 16 cycles; done=1 once.
- frame_len=0 → preamble plus 8 header symbols 00, then GAP directly; in_ready never asserts.
- frame_len=3, out_ready toggling 1/0 each cycle → symbol held stable while ready low; 12 payload symbols in order; no drops or duplicates.
- in_valid low for 5 cycles after byte 1 of 2 → underrun=1, out_valid gap, then byte 2 symbols follow; underrun clears on next start.
- start pulsed during HEADER with frame_len=9 → ignored; header and payload use the original length.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK frame sequencer.
package qpsk_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_HEADER   = 3'd2,
      S_PAYLOAD  = 3'd3,
      S_GAP      = 3'd4
   } state_e;

   localparam logic [1:0] PRE_SYM_EVEN  = 2'b00;
   localparam logic [1:0] PRE_SYM_ODD   = 2'b11;
   localparam int         HDR_W         = 16;
   localparam int         SYMS_PER_BYTE = 4;
   localparam int         BYTE_W        = 2 * SYMS_PER_BYTE;

   // Preamble alternates 00/11, starting with 00 on symbol 0.
   function automatic logic [1:0] preamble_sym(input logic odd);
      return odd ? PRE_SYM_ODD : PRE_SYM_EVEN;
   endfunction

endpackage

// File: rtl/qpsk_sym_shifter.sv
// Parallel-load word shifter that hands out 2-bit symbols MSB first.
// load_skip loads a word whose first symbol was already consumed elsewhere
// (bypassed straight to the output register), so only W/2-1 symbols remain.
module qpsk_sym_shifter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         load_skip,
   input  logic         adv,
   input  logic [W-1:0] word,
   output logic [1:0]   sym,
   output logic         empty,
   output logic         last
);

   localparam int N  = W / 2;
   localparam int CW = $clog2(N + 1);

   logic [W-1:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Load has priority over advance; an advance on an empty shifter is a no-op.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         if (load_skip) begin
            data_d = {word[W-3:0], 2'b00};
            cnt_d  = CW'(N - 1);
         end else begin
            data_d = word;
            cnt_d  = CW'(N);
         end
      end else if (adv && (cnt_q != '0)) begin
         data_d = {data_q[W-3:0], 2'b00};
         cnt_d  = cnt_q - CW'(1);
      end
   end

   // Shift register and remaining-symbol count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sym   = data_q[W-1:W-2];
   assign empty = (cnt_q == '0);
   assign last  = (cnt_q == CW'(1));

endmodule

// File: rtl/qpsk_frame_ctrl.sv
// Frame sequencer: preamble, 16-bit length header, payload bytes, then a
// silent gap, delivered two bits per symbol into a single output register.
// Handshakes: a beat moves on a rising edge where valid & ready are both high;
// out_valid never drops and the symbol never changes while out_ready is low.
module qpsk_frame_ctrl
   import qpsk_pkg::*;
#(
   parameter int PREAMBLE_SYMS = 32,
   parameter int GAP_CYCLES    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] frame_len,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_i,
   output logic        out_q,
   output logic        out_valid,
   input  logic        out_ready,
   output state_e      dbg_state
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] bytes_left_q, bytes_left_d;
   logic [1:0]  out_sym_q, out_sym_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        underrun_q, underrun_d;

   logic        load_en, in_fire;
   logic        hdr_load, hdr_adv, hdr_empty, hdr_last;
   logic [1:0]  hdr_sym;
   logic        pay_load, pay_skip, pay_adv, pay_empty, pay_last;
   logic [1:0]  pay_sym;

   // The output register may take a new symbol when empty or draining.
   assign load_en  = ~out_valid_q | out_ready;
   assign in_ready = (state_q == S_PAYLOAD) && (bytes_left_q != 16'd0) &&
                     (pay_empty || (pay_last && load_en));
   assign in_fire  = in_valid & in_ready;

   qpsk_sym_shifter #(.W(HDR_W)) u_hdr (
      .clk(clk), .rst_n(rst_n), .load(hdr_load), .load_skip(1'b0),
      .adv(hdr_adv), .word(frame_len), .sym(hdr_sym),
      .empty(hdr_empty), .last(hdr_last)
   );

   qpsk_sym_shifter #(.W(BYTE_W)) u_pay (
      .clk(clk), .rst_n(rst_n), .load(pay_load), .load_skip(pay_skip),
      .adv(pay_adv), .word(in_data), .sym(pay_sym),
      .empty(pay_empty), .last(pay_last)
   );

   // Next-state, counters and next output-register contents.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bytes_left_d = bytes_left_q;
      out_sym_d    = out_sym_q;
      out_valid_d  = out_valid_q;
      underrun_d   = underrun_q;
      done_d       = 1'b0;
      hdr_load     = 1'b0;
      hdr_adv      = 1'b0;
      pay_load     = 1'b0;
      pay_skip     = 1'b0;
      pay_adv      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_PREAMBLE;
               bytes_left_d = frame_len;
               hdr_load     = 1'b1;
               underrun_d   = 1'b0;
               cnt_d        = 16'd0;
            end
         end
         S_PREAMBLE: begin
            if (load_en) begin
               out_valid_d = 1'b1;
               out_sym_d   = preamble_sym(cnt_q[0]);
               if (cnt_q == 16'(PREAMBLE_SYMS - 1)) begin
                  cnt_d   = 16'd0;
                  state_d = S_HEADER;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_HEADER: begin
            if (load_en) begin
               if (!hdr_empty) begin
                  out_valid_d = 1'b1;
                  out_sym_d   = hdr_sym;
                  hdr_adv     = 1'b1;
                  if (hdr_last && (bytes_left_q != 16'd0)) state_d = S_PAYLOAD;
               end else begin
                  // Zero-length frame: last header symbol has just transferred.
                  out_valid_d = 1'b0;
                  cnt_d       = 16'd0;
                  state_d     = S_GAP;
               end
            end
         end
         S_PAYLOAD: begin
            if (in_fire) begin
               bytes_left_d = bytes_left_q - 16'd1;
               pay_load     = 1'b1;
            end
            if (load_en) begin
               if (!pay_empty) begin
                  out_valid_d = 1'b1;
                  out_sym_d   = pay_sym;
                  pay_adv     = 1'b1;
               end else if (in_fire) begin
                  // Bypass the first symbol of a fresh byte to avoid a bubble.
                  out_valid_d = 1'b1;
                  out_sym_d   = in_data[7:6];
                  pay_skip    = 1'b1;
               end else begin
                  out_valid_d = 1'b0;
                  if (bytes_left_q == 16'd0) begin
                     cnt_d   = 16'd0;
                     state_d = S_GAP;
                  end else begin
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            out_valid_d = 1'b0;
            if (cnt_q == 16'(GAP_CYCLES - 1)) begin
               cnt_d   = 16'd0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Single state register for the FSM, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 16'd0;
         bytes_left_q <= 16'd0;
         out_sym_q    <= 2'b00;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bytes_left_q <= bytes_left_d;
         out_sym_q    <= out_sym_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign out_i     = out_sym_q[1];
   assign out_q     = out_sym_q[0];
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Directed bench for qpsk_frame_ctrl with a 4-symbol preamble and 16-cycle gap.
module tb_qpsk_frame_ctrl;
   import qpsk_pkg::*;

   localparam int P_SYMS = 4;
   localparam int G_CYC  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start;
   logic [15:0] frame_len;
   logic        busy, done, underrun;
   logic [7:0]  in_data;
   logic        in_valid, in_ready;
   logic        out_i, out_q, out_valid, out_ready;
   state_e      dbg_state;

   qpsk_frame_ctrl #(.PREAMBLE_SYMS(P_SYMS), .GAP_CYCLES(G_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
      .busy(busy), .done(done), .underrun(underrun),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
      .dbg_state(dbg_state)
   );

   typedef struct {
      logic [15:0] len;
      logic [7:0]  data [3];
      int          ready_mode;   // 0: out_ready held high, 1: toggles every cycle
      int          stall_at;     // in_valid drops once this many bytes are taken (-1: never)
      int          stall_cyc;
      bit          mid_start;    // pulse start (frame_len=9) while in HEADER
      int          exp_cycles;   // start edge to done edge (0: not checked)
      bit          exp_underrun;
      bit          exp_in_ready;
   } vec_t;

   int         n_cmp = 0;
   int         n_fail = 0;
   string      cur_tag = "init";
   logic [1:0] exp_q[$];
   logic [1:0] exp_sym;
   logic [7:0] src_mem [8];
   int         src_len, src_idx, stall_at, stall_cyc, stall_left, ready_mode;
   int         done_cnt;
   bit         in_ready_seen;
   bit         hold_chk;
   logic [1:0] hold_sym;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (in_ready) in_ready_seen = 1'b1;
         if (hold_chk) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sym", 32'({out_i, out_q}), 32'(hold_sym));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL %s/extra_symbol: got %0d%0d expected no symbol", cur_tag, out_i, out_q);
            end else begin
               exp_sym = exp_q.pop_front();
               check("symbol", 32'({out_i, out_q}), 32'(exp_sym));
            end
         end
         if (dbg_state == S_GAP) begin
            check("gap_out_valid", 32'(out_valid), 0);
            check("gap_in_ready", 32'(in_ready), 0);
         end
         hold_chk = out_valid && !out_ready;
         hold_sym = {out_i, out_q};
      end else begin
         hold_chk = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      logic fire;
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (fire) src_idx++;
      out_ready = (ready_mode == 1) ? ~out_ready : 1'b1;
      if (fire && (src_idx == stall_at)) stall_left = stall_cyc;
      else if (stall_left > 0) stall_left--;
      in_valid = (src_idx < src_len) && (stall_left == 0);
      in_data  = (src_idx < 8) ? src_mem[src_idx] : 8'h00;
   endtask

   task automatic setup_src(input vec_t v);
      for (int i = 0; i < 8; i++) src_mem[i] = (i < 3) ? v.data[i] : 8'h00;
      src_len    = int'(v.len);
      src_idx    = 0;
      stall_at   = v.stall_at;
      stall_cyc  = v.stall_cyc;
      stall_left = 0;
      ready_mode = v.ready_mode;
      out_ready  = 1'b1;
      in_valid   = (src_len > 0);
      in_data    = src_mem[0];
   endtask

   function automatic void push_model(input vec_t v);
      for (int k = 0; k < P_SYMS; k++) exp_q.push_back((k % 2 == 1) ? 2'b11 : 2'b00);
      for (int j = 0; j < 8; j++) exp_q.push_back(v.len[15-2*j -: 2]);
      for (int b = 0; b < int'(v.len); b++)
         for (int s = 0; s < 4; s++) exp_q.push_back(v.data[b][7-2*s -: 2]);
   endfunction

   function automatic vec_t mk(input logic [15:0] len, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int rm, input int sa, input int sc,
                               input bit ms, input int ec, input bit eu, input bit er);
      vec_t v;
      v.len = len; v.data[0] = b0; v.data[1] = b1; v.data[2] = b2;
      v.ready_mode = rm; v.stall_at = sa; v.stall_cyc = sc; v.mid_start = ms;
      v.exp_cycles = ec; v.exp_underrun = eu; v.exp_in_ready = er;
      return v;
   endfunction

   task automatic recover();
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   // Runs one frame whose expected symbols are already queued in exp_q.
   task automatic run_vec(input vec_t v);
      int  k;
      bit  mid_done;
      setup_src(v);
      done_cnt      = 0;
      in_ready_seen = 1'b0;
      frame_len     = v.len;
      start         = 1'b1;
      tick();
      start     = 1'b0;
      frame_len = 16'hFFFF;
      check("busy_after_start", 32'(busy), 1);
      check("underrun_after_start", 32'(underrun), 0);
      check("valid_latency1", 32'(out_valid), 0);
      tick();
      check("valid_latency2", 32'(out_valid), 1);
      check("first_sym", 32'({out_i, out_q}), 0);
      k = 1;
      mid_done = 1'b0;
      while (!done && k < 2000) begin
         start = 1'b0;
         if (v.mid_start && !mid_done && dbg_state == S_HEADER) begin
            start     = 1'b1;
            frame_len = 16'd9;
            mid_done  = 1'b1;
         end
         tick();
         k++;
      end
      start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s/timeout: got no done after %0d cycles expected done", cur_tag, k);
         recover();
         return;
      end
      check("busy_at_done", 32'(busy), 0);
      if (v.exp_cycles != 0) check("frame_cycles", 32'(k), 32'(v.exp_cycles));
      repeat (3) tick();
      check("done_pulses", 32'(done_cnt), 1);
      check("symbols_left", 32'(exp_q.size()), 0);
      check("bytes_taken", 32'(src_idx), 32'(v.len));
      check("underrun_end", 32'(underrun), 32'(v.exp_underrun));
      check("in_ready_seen", 32'(in_ready_seen), 32'(v.exp_in_ready));
   endtask

   // ---------------- test sequence ----------------
   vec_t       vecs [5];
   vec_t       hv;
   logic [1:0] b4_syms [16];
   int         k;

   initial begin
      vecs[0] = mk(16'd0, 8'h00, 8'h00, 8'h00, 0, -1, 0, 1'b0, 29, 1'b0, 1'b0);
      vecs[1] = mk(16'd3, 8'h3C, 8'hA5, 8'h0F, 1, -1, 0, 1'b0, 0,  1'b0, 1'b1);
      vecs[2] = mk(16'd2, 8'h5A, 8'hC3, 8'h00, 0, 1,  5, 1'b0, 0,  1'b1, 1'b1);
      vecs[3] = mk(16'd2, 8'h81, 8'h7E, 8'h00, 0, -1, 0, 1'b1, 37, 1'b0, 1'b1);
      vecs[4] = mk(16'd3, 8'hE1, 8'h2D, 8'h96, 0, -1, 0, 1'b0, 41, 1'b0, 1'b1);
      b4_syms = '{2'b00, 2'b11, 2'b00, 2'b11,
                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                  2'b10, 2'b11, 2'b01, 2'b00};

      rst_n = 1'b0; start = 1'b0; frame_len = 16'd0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      ready_mode = 0; src_len = 0; src_idx = 0; stall_at = -1; stall_cyc = 0; stall_left = 0;
      repeat (2) @(posedge clk);
      #1;
      cur_tag = "reset";
      check("out_valid", 32'(out_valid), 0);
      check("out_iq", 32'({out_i, out_q}), 0);
      check("busy", 32'(busy), 0);
      check("done", 32'(done), 0);
      check("underrun", 32'(underrun), 0);
      check("in_ready", 32'(in_ready), 0);
      check("state", 32'(dbg_state), 32'(S_IDLE));
      rst_n = 1'b1;
      tick();

      // Hand-computed frame: one payload byte 8'hB4.
      cur_tag = "hand_b4";
      for (int i = 0; i < 16; i++) exp_q.push_back(b4_syms[i]);
      hv = mk(16'd1, 8'hB4, 8'h00, 8'h00, 0, -1, 0, 1'b0, 33, 1'b0, 1'b1);
      run_vec(hv);

      for (int i = 0; i < 5; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         push_model(vecs[i]);
         run_vec(vecs[i]);
      end

      // Asynchronous reset in the middle of the payload.
      cur_tag = "reset_mid";
      hv = mk(16'd2, 8'h12, 8'h34, 8'h00, 0, -1, 0, 1'b0, 0, 1'b0, 1'b1);
      setup_src(hv);
      push_model(hv);
      done_cnt  = 0;
      frame_len = hv.len;
      start     = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (dbg_state != S_PAYLOAD && k < 200) begin
         tick();
         k++;
      end
      check("reached_payload", 32'(dbg_state), 32'(S_PAYLOAD));
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("out_valid", 32'(out_valid), 0);
      check("out_iq", 32'({out_i, out_q}), 0);
      check("busy", 32'(busy), 0);
      check("done", 32'(done), 0);
      check("underrun", 32'(underrun), 0);
      check("in_ready", 32'(in_ready), 0);
      exp_q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      src_len = 0;
      repeat (20) tick();
      check("no_done_after_reset", 32'(done_cnt), 0);
      check("idle_after_reset", 32'(busy), 0);

      cur_tag = "after_reset";
      push_model(vecs[4]);
      run_vec(vecs[4]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
